monocicle_trace_buffer: RTL and testbench

//  Synthesizable execution-trace recorder for the single-cycle core. Replaces the simulation-only
//  per-cycle print of pc / instruction / ALU result / data RAM with an on-chip circular capture.

---
 rtl/monocicle_trace_buffer_pkg.sv | 26 ++
 rtl/monocicle_trace_buffer_if.sv | 28 ++
 rtl/monocicle_trace_buffer_trace_ram.sv | 34 +++
 rtl/monocicle_trace_buffer.sv | 156 +++++++++++++++
 tb/tb_monocicle_trace_buffer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/monocicle_trace_buffer_pkg.sv
// Shared types and constants for the monocicle execution-trace recorder.
// Channel indices give the slice order inside one captured sample (pc in the LSBs).
package monocicle_trace_buffer_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_POST_TRIG = 8;

  localparam int NUM_CH   = 4;
  localparam int CH_PC    = 0;
  localparam int CH_INSTR = 1;
  localparam int CH_ALU   = 2;
  localparam int CH_DRAM  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POST    = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  function automatic logic is_capturing(input state_t s);
    return (s == ST_ARMED) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/monocicle_trace_buffer_if.sv
// Readout stream of the trace buffer: one captured sample per transfer, oldest first.
interface monocicle_trace_buffer_if #(
  parameter int DATA_W = 32
) ();
  import monocicle_trace_buffer_pkg::*;

  // A sample moves on every rising edge where rd_valid && rd_ready. Once rd_valid is
  // high, rd_data and rd_last stay constant until that transfer; rd_ready may change freely.
  logic                     rd_valid;
  logic                     rd_ready;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic                     rd_last;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_last,
    output rd_ready
  );

endinterface

// File: rtl/monocicle_trace_buffer_trace_ram.sv
// Simple dual-port sample store: synchronous write, registered read with hold-on-idle.
// The read register is the readout data register, so it only advances when re is high.
module monocicle_trace_buffer_trace_ram #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/monocicle_trace_buffer.sv
// Circular execution-trace capture for the single-cycle core: records pc/instr/alu/dram
// every clock while armed, stops on a pc match (plus post-trigger samples) or when full.
module monocicle_trace_buffer
  import monocicle_trace_buffer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int POST_TRIG = DEF_POST_TRIG
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        pc_in,
  input  logic [DATA_W-1:0]        instr_in,
  input  logic [DATA_W-1:0]        alures_in,
  input  logic [DATA_W-1:0]        dram_in,
  input  logic                     arm,
  input  logic                     mode,
  input  logic [DATA_W-1:0]        trig_pc,
  monocicle_trace_buffer_if.master rd,
  output logic                     busy,
  output logic                     triggered,
  output logic [$clog2(DEPTH):0]   count,
  output state_t                   state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] POST_LIM = CNT_W'(POST_TRIG);
  localparam int SAMPLE_W = NUM_CH * DATA_W;

  state_t             state, state_nx;
  logic [PTR_W-1:0]   wr_ptr, rd_addr;
  logic [CNT_W-1:0]   cnt, cnt_inc, rd_idx, post_cnt;
  logic               trig_q, valid_q, last_q;
  logic               capture, hit, fill, ren, xfer, done;
  logic [SAMPLE_W-1:0] wdata, ram_q;

  always_comb begin
    wdata = '0;
    wdata[CH_PC*DATA_W    +: DATA_W] = pc_in;
    wdata[CH_INSTR*DATA_W +: DATA_W] = instr_in;
    wdata[CH_ALU*DATA_W   +: DATA_W] = alures_in;
    wdata[CH_DRAM*DATA_W  +: DATA_W] = dram_in;
  end

  // arm always wins: the arm edge itself neither captures nor triggers.
  always_comb begin
    capture = is_capturing(state) && !arm;
    cnt_inc = (cnt == FULL) ? cnt : cnt + CNT_W'(1);
    hit     = (state == ST_ARMED) && !arm && !mode && (pc_in == trig_pc);
    fill    = (state == ST_ARMED) && !arm && mode && (cnt_inc == FULL);
    xfer    = valid_q && rd.rd_ready;
    done    = xfer && last_q;
    ren     = (state == ST_READOUT) && !arm && (rd_idx < cnt) && (!valid_q || rd.rd_ready);
    // Oldest sample sits count entries behind the write pointer; DEPTH wraps to zero.
    rd_addr = wr_ptr - cnt[PTR_W-1:0] + rd_idx[PTR_W-1:0];
  end

  always_comb begin
    state_nx = state;
    if (arm) begin
      state_nx = ST_ARMED;
    end else begin
      case (state)
        ST_IDLE:    state_nx = ST_IDLE;
        ST_ARMED: begin
          if (hit) begin
            if (POST_TRIG == 0) state_nx = ST_READOUT;
            else                state_nx = ST_POST;
          end else if (fill) begin
            state_nx = ST_READOUT;
          end
        end
        ST_POST: begin
          if (post_cnt + CNT_W'(1) == POST_LIM) state_nx = ST_READOUT;
        end
        ST_READOUT: begin
          if (done) state_nx = ST_IDLE;
        end
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      cnt      <= '0;
      rd_idx   <= '0;
      post_cnt <= '0;
      trig_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (arm) begin
        wr_ptr   <= '0;
        cnt      <= '0;
        rd_idx   <= '0;
        post_cnt <= '0;
        trig_q   <= 1'b0;
        valid_q  <= 1'b0;
        last_q   <= 1'b0;
      end else begin
        if (capture) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          cnt    <= cnt_inc;
        end
        if (hit || fill) begin
          trig_q <= 1'b1;
        end
        if (state == ST_POST) begin
          post_cnt <= post_cnt + CNT_W'(1);
        end
        // The RAM read register doubles as the output register, so a new read is
        // issued only when the current sample is absent or leaving this cycle.
        if (ren) begin
          rd_idx  <= rd_idx + CNT_W'(1);
          valid_q <= 1'b1;
          last_q  <= (rd_idx + CNT_W'(1) == cnt);
        end else if (xfer) begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
        if (done) begin
          rd_idx <= '0;
        end
      end
    end
  end

  monocicle_trace_buffer_trace_ram #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (ren),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  assign rd.rd_valid = valid_q;
  assign rd.rd_data  = ram_q;
  assign rd.rd_last  = last_q;
  assign busy        = is_capturing(state);
  assign triggered   = trig_q;
  assign count       = cnt;
  assign state_dbg   = state;

endmodule

// File: tb/tb_monocicle_trace_buffer.sv
// Directed bench for monocicle_trace_buffer: window model built from the capture rules,
// per-transfer scoreboard on the readout port, and literal pins for each scenario.
module tb_monocicle_trace_buffer;
  import monocicle_trace_buffer_pkg::*;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 8;
  localparam int W         = 4 * DATA_W;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] pc_in, instr_in, alures_in, dram_in, trig_pc;
  logic              arm, mode;
  logic              busy, triggered;
  logic [4:0]        count;
  state_t            state_dbg;

  monocicle_trace_buffer_if #(.DATA_W(DATA_W)) rd_if ();

  monocicle_trace_buffer #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .POST_TRIG (POST_TRIG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .alures_in (alures_in),
    .dram_in   (dram_in),
    .arm       (arm),
    .mode      (mode),
    .trig_pc   (trig_pc),
    .rd        (rd_if.master),
    .busy      (busy),
    .triggered (triggered),
    .count     (count),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp;
  int          n_bad;
  logic [W-1:0] exp_q[$];
  logic [31:0]  seen_pc[$];
  logic         stall_prev;
  logic [W-1:0] held;
  logic [W-1:0] exp_item;

  function automatic logic [W-1:0] mk(input logic [31:0] pc);
    return {~pc, pc * 32'd3, pc ^ 32'hA5A5_0000, pc};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: all enter and leave 1 time unit after a rising edge
  task automatic drive_pc(input logic [31:0] pc);
    logic [W-1:0] s;
    s = mk(pc);
    pc_in     = s[31:0];
    instr_in  = s[63:32];
    alures_in = s[95:64];
    dram_in   = s[127:96];
  endtask

  task automatic pulse_arm(input logic m, input logic [31:0] tpc);
    mode    = m;
    trig_pc = tpc;
    drive_pc(tpc);
    arm         = 1'b1;
    rd_if.rd_ready = 1'b0;
    exp_q.delete();
    seen_pc.delete();
    @(posedge clk); #1;
    arm = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_count", count, 0);
    check("arm_triggered", triggered, 0);
    check("arm_rd_valid", rd_if.rd_valid, 0);
  endtask

  // Model: stream pc = 4*i from the first cycle after arm; trigger/fill decides
  // how many samples n are stored; the window is the last min(n, DEPTH) of them.
  task automatic build_expected(input logic m, input logic [31:0] tpc, output int n);
    int k;
    k = -1;
    if (m) begin
      n = DEPTH;
    end else begin
      for (int i = 0; i < 200; i++) begin
        if (k < 0 && 32'(4 * i) == tpc) k = i;
      end
      n = k + 1 + POST_TRIG;
    end
    for (int i = (n > DEPTH) ? n - DEPTH : 0; i < n; i++) begin
      exp_q.push_back(mk(32'(4 * i)));
    end
  endtask

  task automatic capture_stream(input logic m, input logic [31:0] tpc);
    int n;
    bit stopped;
    build_expected(m, tpc, n);
    stopped = 1'b0;
    for (int i = 0; i < 200 && !stopped; i++) begin
      drive_pc(32'(4 * i));
      @(posedge clk); #1;
      if (!busy) stopped = 1'b1;
    end
    check("capture_stopped", stopped, 1);
    check("capture_count", count, (n > DEPTH) ? DEPTH : n);
    check("capture_triggered", triggered, 1);
    check("valid_low_on_readout_entry", rd_if.rd_valid, 0);
  endtask

  task automatic read_out(input int sel, input int max_x);
    int cyc;
    bit fin;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 400) begin
      rd_if.rd_ready = (sel == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(posedge clk); #1;
      cyc++;
      if (seen_pc.size() >= max_x) fin = 1'b1;
      else if (exp_q.size() == 0 && !rd_if.rd_valid) fin = 1'b1;
    end
    check("readout_finished", fin, 1);
  endtask

  task automatic check_idle_after(input int exp_cnt);
    rd_if.rd_ready = 1'b0;
    check("done_rd_valid", rd_if.rd_valid, 0);
    check("done_busy", busy, 0);
    check("done_state_idle", state_dbg, ST_IDLE);
    check("done_count_held", count, exp_cnt);
    check("done_triggered_held", triggered, 1);
    check("done_samples_read", seen_pc.size(), exp_cnt);
    check("done_queue_drained", exp_q.size(), 0);
  endtask

  // scoreboard: every transfer pops the oldest expected sample
  always @(negedge clk) begin
    if (stall_prev) begin
      check("stall_valid_held", rd_if.rd_valid, 1);
      check("stall_data_held", rd_if.rd_data, held);
    end
    if (rd_if.rd_valid) begin
      check("valid_while_capturing", busy, 0);
      if (rd_if.rd_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_sample: got 0x%0h, expected no transfer", rd_if.rd_data);
        end else begin
          exp_item = exp_q.pop_front();
          check("sample_data", rd_if.rd_data, exp_item);
          check("sample_last", rd_if.rd_last, exp_q.size() == 0);
          seen_pc.push_back(rd_if.rd_data[31:0]);
        end
      end
    end
    stall_prev = rd_if.rd_valid && !rd_if.rd_ready && !arm && rst_n;
    held       = rd_if.rd_data;
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    stall_prev = 1'b0;
    rst_n = 1'b0;
    arm = 1'b0;
    mode = 1'b0;
    trig_pc = '0;
    rd_if.rd_ready = 1'b0;
    drive_pc(32'h0);

    // 1: reset with random inputs
    repeat (4) begin
      @(posedge clk); #1;
      drive_pc($urandom);
      trig_pc = $urandom;
      arm = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      rd_if.rd_ready = 1'($urandom_range(0, 1));
    end
    check("reset_rd_valid", rd_if.rd_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_count", count, 0);
    check("reset_triggered", triggered, 0);
    check("reset_rd_last", rd_if.rd_last, 0);
    check("reset_rd_data", rd_if.rd_data, 0);
    check("reset_state", state_dbg, ST_IDLE);
    arm = 1'b0;
    rd_if.rd_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2: trigger before the buffer fills
    pulse_arm(1'b0, 32'h10);
    capture_stream(1'b0, 32'h10);
    read_out(0, 100);
    check_idle_after(13);
    check("t2_first_pc", seen_pc[0], 32'h00);
    check("t2_trigger_pc", seen_pc[4], 32'h10);
    check("t2_last_pc", seen_pc[12], 32'h30);

    // 3 + 5: wrapped buffer, readout with ready pattern 1-0-0-1
    pulse_arm(1'b0, 32'h80);
    capture_stream(1'b0, 32'h80);
    read_out(1, 100);
    check_idle_after(16);
    check("t3_first_pc", seen_pc[0], 32'h64);
    check("t3_trigger_pc", seen_pc[7], 32'h80);
    check("t3_last_pc", seen_pc[15], 32'hA0);

    // 6a: arm during readout aborts and restarts cleanly
    pulse_arm(1'b1, 32'h0);
    capture_stream(1'b1, 32'h0);
    read_out(0, 2);
    check("t6a_partial_reads", seen_pc.size(), 2);
    pulse_arm(1'b0, 32'h10);
    check("t6a_state_armed", state_dbg, ST_ARMED);
    capture_stream(1'b0, 32'h10);
    read_out(1, 100);
    check_idle_after(13);
    check("t6a_first_pc", seen_pc[0], 32'h00);

    // 6b: reset while in POST
    pulse_arm(1'b0, 32'h10);
    for (int i = 0; i < 8; i++) begin
      drive_pc(32'(4 * i));
      @(posedge clk); #1;
    end
    check("t6b_busy_in_post", busy, 1);
    check("t6b_state_post", state_dbg, ST_POST);
    check("t6b_count_in_post", count, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6b_reset_busy", busy, 0);
    check("t6b_reset_count", count, 0);
    check("t6b_reset_triggered", triggered, 0);
    check("t6b_reset_rd_valid", rd_if.rd_valid, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6b_no_resume", state_dbg, ST_IDLE);

    // 4: one-shot fill mode
    pulse_arm(1'b1, 32'h0);
    capture_stream(1'b1, 32'h0);
    read_out(0, 100);
    check_idle_after(16);
    check("t4_first_pc", seen_pc[0], 32'h00);
    check("t4_last_pc", seen_pc[15], 32'h3C);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
